wb_burst_responder: RTL
=======================

Name: wb_burst_responder

Overview:
- Wishbone-classic slave: the memory/BIU end of the instruction-cache refill interface.
- Serves single accesses and CAB line bursts of BURST_LEN 32-bit beats from an internal word-addressed array.
- Drives one-cycle ack pulses with registered read data.
- Used as the unified-memory model behind the I-cache miss FSM, and as a synthesizable boot/scratch RAM.

Parameters:
- MEM_AW, 10, log2 of array depth in 32-bit words.
- BURST_LEN, 8, beats per CAB burst; power of 2; 8 gives a 256-bit line.
- FIRST_LAT, 2, wait cycles between request acceptance and the first ack (0 allowed).
- BEAT_LAT, 0, wait cycles between consecutive burst acks (0 gives back-to-back acks).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  strobe.
- wb_cab_i  in  1  consecutive-address burst request.
- wb_we_i  in  1  1 = write.
- wb_sel_i  in  4  byte lane enables.
- wb_adr_i  in  32  byte address; bits [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid only while wb_ack_o=1.
- wb_ack_o  out  1  beat acknowledge, one-cycle pulse.
- wb_err_o  out  1  error pulse; replaces ack for an out-of-range address.
- busy_o  out  1  1 whenever state is not IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; wb_ack_o=0, wb_err_o=0, wb_dat_o=0, busy_o=0; beat and wait counters = 0.
  - Array contents are not reset.
  - Reset mid-burst aborts the burst with no further ack.
- States: IDLE, WAIT, BEAT, DONE.
- IDLE:
  - On cyc&stb at edge T, latch adr[MEM_AW+1:2] as start word, latch cab and we, set beat=0, load wait count = FIRST_LAT.
  - Next state is WAIT, or BEAT if FIRST_LAT=0.
- WAIT: decrement the wait count each cycle; when it reaches 0, go to BEAT.
  - The first ack is therefore high in cycle T+1+FIRST_LAT.
- BEAT (one cycle, wb_ack_o=1 registered):
  - Word index = {start[MEM_AW-1:log2 BURST_LEN], (start[low] + beat) mod BURST_LEN}, i.e. wrap-within-line.
  - Read: wb_dat_o = mem[index].
  - Write: each byte lane with sel[i]=1 takes wb_dat_i on this edge; wb_dat_o holds its previous value.
  - After a BEAT, go to DONE if cab=0 or beat=BURST_LEN-1. Otherwise beat+1, wait count = BEAT_LAT, and go to WAIT (or BEAT if BEAT_LAT=0).
- Burst timing: acks fall in cycles T+1+FIRST_LAT+k*(BEAT_LAT+1), for k=0..BURST_LEN-1.
- DONE:
  - No ack.
  - Return to IDLE once cyc=0 or stb=0; remain in DONE while both stay high (prevents retriggering on a strobe held one cycle late).
- Abort: cyc_i=0 observed in WAIT or BEAT moves to IDLE at the next edge.
  - A BEAT cycle with cyc_i=0 asserts no ack and does no write.
- Range check:
  - Any adr bit above MEM_AW+1 set → that access terminates with wb_err_o (one pulse, same timing as ack), no ack and no write, then DONE.
  - Addresses are checked only at acceptance, since wrap keeps beats inside the line.
- wb_ack_o and wb_err_o are never high together and never high in IDLE or DONE.
- we, cab and adr are sampled only at acceptance. Changes to them mid-burst are ignored; write data and sel are sampled in each BEAT.

Test Plan:
- FIRST_LAT=2, BEAT_LAT=0, mem[16+i]=0xA000_0000+i; cab burst at adr 0x40 accepted at T → acks at T+3..T+10, data 0xA000_0000..0xA000_0007, then DONE → IDLE after cyc drops.
- Wrap: cab burst at adr 0x48 → data order word indices 18..23,16,17.
- BEAT_LAT=1: burst at 0x40 → acks on alternate cycles T+3, T+5, …, T+17.
- Single write adr 0x100, sel=4'b0010, dat 0x0000_5A00 onto 0x1122_3344 → ack at T+3; a following single read returns 0x1122_5A44.
- Abort: cyc dropped after 3rd ack → no 4th ack, busy_o=0 next cycle; a new request is accepted immediately after.
- rst_n=0 after 2nd beat → all outputs 0 next cycle. Separately, adr 0x0001_0000 (MEM_AW=10) → wb_err_o pulse at T+3, no ack, array unchanged.

Source files
------------

// File: rtl/wb_burst_responder.sv
// Wishbone-classic slave memory serving single accesses and wrap-within-line CAB bursts
// with configurable first-beat and inter-beat latency.
module wb_burst_responder #(
   parameter int unsigned MEM_AW    = 10,
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned FIRST_LAT = 2,
   parameter int unsigned BEAT_LAT  = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_cab_i,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        busy_o
);

   localparam int unsigned LineW  = $clog2(BURST_LEN);
   localparam int unsigned MaxLat = (FIRST_LAT > BEAT_LAT) ? FIRST_LAT : BEAT_LAT;
   localparam int unsigned CntW   = (MaxLat > 0) ? $clog2(MaxLat + 1) : 1;
   localparam int unsigned Depth  = 1 << MEM_AW;

   typedef enum logic [1:0] {StIdle, StWait, StBeat, StDone} state_e;

   state_e              state_q, state_d;
   logic [MEM_AW-1:0]   start_q, start_d;
   logic [LineW-1:0]    beat_q, beat_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                cab_q, cab_d;
   logic                we_q, we_d;
   logic                err_q, err_d;
   logic [31:0]         dat_q, dat_d;
   logic [31:0]         mem_q [Depth];

   logic                req;
   logic                adr_oor;
   logic                mem_we;
   logic [LineW-1:0]    lo_cur, lo_nxt;
   logic [MEM_AW-1:0]   idx_cur, idx_nxt;

   assign req     = wb_cyc_i & wb_stb_i;
   assign adr_oor = |(wb_adr_i >> (MEM_AW + 2));

   // Beat index wraps inside the aligned line; idx_nxt addresses the beat being entered.
   assign lo_cur  = start_q[LineW-1:0] + beat_q;
   assign idx_cur = {start_q[MEM_AW-1:LineW], lo_cur};
   assign lo_nxt  = start_d[LineW-1:0] + beat_d;
   assign idx_nxt = {start_d[MEM_AW-1:LineW], lo_nxt};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         start_q <= '0;
         beat_q  <= '0;
         cnt_q   <= '0;
         cab_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         beat_q  <= beat_d;
         cnt_q   <= cnt_d;
         cab_q   <= cab_d;
         we_q    <= we_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      start_d = start_q;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      cab_d   = cab_q;
      we_d    = we_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               start_d = wb_adr_i[MEM_AW+1:2];
               cab_d   = wb_cab_i;
               we_d    = wb_we_i;
               err_d   = adr_oor;
               beat_d  = '0;
               cnt_d   = CntW'(FIRST_LAT);
               state_d = (FIRST_LAT == 0) ? StBeat : StWait;
            end
         end
         StWait: begin
            if (!wb_cyc_i) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - CntW'(1);
               if (cnt_q <= CntW'(1)) state_d = StBeat;
            end
         end
         StBeat: begin
            if (!wb_cyc_i) begin
               state_d = StIdle;
            end else if (err_q || !cab_q || (beat_q == '1)) begin
               state_d = StDone;
            end else begin
               beat_d  = beat_q + LineW'(1);
               cnt_d   = CntW'(BEAT_LAT);
               state_d = (BEAT_LAT == 0) ? StBeat : StWait;
            end
         end
         StDone: begin
            if (!req) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Read data is fetched on the edge that enters a beat so it is registered during the ack.
   always_comb begin
      dat_d = dat_q;
      if ((state_d == StBeat) && !we_d && !err_d) dat_d = mem_q[idx_nxt];
   end

   always_comb begin
      wb_ack_o = (state_q == StBeat) && wb_cyc_i && !err_q;
      wb_err_o = (state_q == StBeat) && wb_cyc_i && err_q;
      busy_o   = (state_q != StIdle);
      mem_we   = (state_q == StBeat) && wb_cyc_i && we_q && !err_q && rst_n;
   end

   assign wb_dat_o = dat_q;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (wb_sel_i[i]) mem_q[idx_cur][8*i +: 8] <= wb_dat_i[8*i +: 8];
         end
      end
   end

endmodule
